// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and width helper for the serial pattern detector
package seq_det_pkg;
    typedef enum logic {MODE_OVL, MODE_NOVL} mode_e;
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction
endpackage

// File: rtl/seq_det_hist.sv
// seq_det_hist: bit history shift register plus saturating fill counter
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int FW    = fill_w(PAT_W)
) (
    input  logic             clock,
    input  logic             reset_in,
    input  logic             shift,
    input  logic             din,
    input  logic             clr_fill,
    input  logic             clr_all,
    output logic [PAT_W-1:0] history,
    output logic [FW-1:0]    fill
);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            history <= '0;
            fill    <= '0;
        end else if (clr_all) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= {history[PAT_W-2:0], din};
            fill    <= clr_fill ? '0 : (fill == FULL ? fill : fill + 1'b1);
        end
    end
endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: serial pattern detector with runtime-loadable pattern;
// the saturating match counter and match_cnt port exist only under SEQ_DET_CNT_EN
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(3'b101),
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset_in,
    input  logic             seq_in,
    input  logic             seq_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             detect_out
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);
    localparam int    FW   = fill_w(PAT_W);
    localparam mode_e MODE = (OVERLAP != 0) ? MODE_OVL : MODE_NOVL;

    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] history;
    logic [FW-1:0]    fill;
    logic             shift;
    logic             match;
    logic             unused_hist_msb;

    // a load discards the incoming bit, so it also blocks shifting and matching
    assign shift = seq_valid & ~pat_load;
    assign match = shift && fill >= FW'(PAT_W - 1) && {history[PAT_W-2:0], seq_in} == pattern;
    assign unused_hist_msb = history[PAT_W-1];

    seq_det_hist #(.PAT_W(PAT_W), .FW(FW)) u_hist (
        .clock    (clock),
        .reset_in (reset_in),
        .shift    (shift),
        .din      (seq_in),
        .clr_fill (match && MODE == MODE_NOVL),
        .clr_all  (pat_load),
        .history  (history),
        .fill     (fill)
    );

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            pattern    <= RST_PAT;
            detect_out <= 1'b0;
        end else begin
            pattern    <= pat_load ? pat_in : pattern;
            detect_out <= match;
        end
    end

`ifdef SEQ_DET_CNT_EN
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in)
            match_cnt <= '0;
        else if (cnt_clr)
            match_cnt <= '0;
        else if (match && match_cnt != '1)
            match_cnt <= match_cnt + 1'b1;
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
`endif
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed plus random stimulus on three detector variants, checked against a bit-window model
module tb_seq_det_param;
    logic       clock;
    logic       reset_in;
    logic       seq_in;
    logic       seq_valid;
    logic       pat_load;
    logic       cnt_clr;
    logic [2:0] pin_a;
    logic [3:0] pin_c;
    logic       det_a, det_b, det_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int errors = 0;
    int checks = 0;

    // model: pattern width, overlap mode, counter ceiling, reset pattern per instance
    int pw[3]   = '{3, 3, 4};
    int ovl[3]  = '{1, 0, 1};
    int cmax[3] = '{255, 255, 3};
    int rpat[3] = '{5, 5, 5};
    int pat[3], win[3], fresh[3], mc[3], ed[3];

    seq_det_param #(.PAT_W(3), .RST_PAT(3'b101), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clock(clock), .reset_in(reset_in), .seq_in(seq_in), .seq_valid(seq_valid),
        .pat_load(pat_load), .pat_in(pin_a), .cnt_clr(cnt_clr), .detect_out(det_a)
`ifdef SEQ_DET_CNT_EN
        , .match_cnt(cnt_a)
`endif
    );

    seq_det_param #(.PAT_W(3), .RST_PAT(3'b101), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clock(clock), .reset_in(reset_in), .seq_in(seq_in), .seq_valid(seq_valid),
        .pat_load(pat_load), .pat_in(pin_a), .cnt_clr(cnt_clr), .detect_out(det_b)
`ifdef SEQ_DET_CNT_EN
        , .match_cnt(cnt_b)
`endif
    );

    seq_det_param #(.PAT_W(4), .RST_PAT(4'b0101), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clock(clock), .reset_in(reset_in), .seq_in(seq_in), .seq_valid(seq_valid),
        .pat_load(pat_load), .pat_in(pin_c), .cnt_clr(cnt_clr), .detect_out(det_c)
`ifdef SEQ_DET_CNT_EN
        , .match_cnt(cnt_c)
`endif
    );

`ifndef SEQ_DET_CNT_EN
    assign cnt_a = '0;
    assign cnt_b = '0;
    assign cnt_c = '0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/det_a"}, 32'(det_a), ed[0]);
        check({tag, "/det_b"}, 32'(det_b), ed[1]);
        check({tag, "/det_c"}, 32'(det_c), ed[2]);
`ifdef SEQ_DET_CNT_EN
        check({tag, "/cnt_a"}, 32'(cnt_a), mc[0]);
        check({tag, "/cnt_b"}, 32'(cnt_b), mc[1]);
        check({tag, "/cnt_c"}, 32'(cnt_c), mc[2]);
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pat[i] = rpat[i];
            win[i] = 0;
            fresh[i] = 0;
            mc[i] = 0;
            ed[i] = 0;
        end
    endtask

    // a match is: at least pw bits received since the last clear and the last pw of them equal the pattern
    task automatic step(input logic b, input logic v, input logic pl, input logic cc, input string tag);
        seq_in = b;
        seq_valid = v;
        pat_load = pl;
        cnt_clr = cc;
        for (int i = 0; i < 3; i++) begin
            ed[i] = 0;
            if (pl) begin
                pat[i] = (i == 2) ? int'(pin_c) : int'(pin_a);
                win[i] = 0;
                fresh[i] = 0;
            end else if (v) begin
                win[i] = (win[i] * 2 + int'(b)) % (1 << pw[i]);
                fresh[i]++;
                if (fresh[i] >= pw[i] && win[i] == pat[i]) begin
                    ed[i] = 1;
                    if (ovl[i] == 0) fresh[i] = 0;
                end
            end
            mc[i] = cc ? 0 : (ed[i] == 1 && mc[i] < cmax[i]) ? mc[i] + 1 : mc[i];
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [4:0] s5;
        logic [3:0] s4;
        reset_in = 1'b1;
        seq_in = 1'b0;
        seq_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr = 1'b0;
        pin_a = 3'b101;
        pin_c = 4'b1101;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clock);
        reset_in = 1'b0;

        s5 = 5'b10101;
        for (int k = 4; k >= 0; k--) step(s5[k], 1'b1, 1'b0, 1'b0, "stream10101");

        step(1'b0, 1'b0, 1'b1, 1'b0, "load");
        s4 = 4'b1101;
        for (int k = 3; k >= 0; k--) step(s4[k], 1'b1, 1'b0, 1'b0, "p1101");
        step(1'b0, 1'b0, 1'b1, 1'b0, "reload");
        for (int k = 2; k >= 0; k--) step(s5[k], 1'b1, 1'b0, 1'b0, "p101_short");

        step(1'b0, 1'b0, 1'b1, 1'b0, "gap_load");
        step(1'b1, 1'b1, 1'b0, 1'b0, "gap_b1");
        step(1'b0, 1'b1, 1'b0, 1'b0, "gap_b2");
        for (int k = 0; k < 5; k++) step(1'($urandom), 1'b0, 1'b0, 1'b0, "gap_idle");
        step(1'b1, 1'b1, 1'b0, 1'b0, "gap_b3");

        step(1'b0, 1'b0, 1'b1, 1'b0, "rst_load");
        step(1'b1, 1'b1, 1'b0, 1'b0, "rst_b1");
        step(1'b0, 1'b1, 1'b0, 1'b0, "rst_b2");
        step(1'b1, 1'b1, 1'b0, 1'b0, "rst_b3");
        #3;
        reset_in = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clock);
        reset_in = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, "post_rst");
        step(1'b0, 1'b1, 1'b0, 1'b0, "post_rst");

        step(1'b0, 1'b0, 1'b1, 1'b0, "cnt_load");
        for (int r = 0; r < 5; r++)
            for (int k = 3; k >= 0; k--) step(s4[k], 1'b1, 1'b0, 1'b0, "cnt_sat");
        for (int k = 3; k >= 1; k--) step(s4[k], 1'b1, 1'b0, 1'b0, "cnt_pre");
        step(1'b1, 1'b1, 1'b0, 1'b1, "clr_hit");
        step(1'b0, 1'b0, 1'b0, 1'b0, "clr_after");

        step(1'b1, 1'b1, 1'b1, 1'b0, "load_wins");

        for (int r = 0; r < 400; r++) begin
            logic pl;
            pl = ($urandom_range(0, 19) == 0);
            if (pl) begin
                pin_a = 3'($urandom);
                pin_c = 4'($urandom);
            end
            step(1'($urandom), $urandom_range(0, 3) != 0, pl, $urandom_range(0, 29) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter RST_PAT, default 3'b101: pattern loaded at reset; MSB is the first-received bit.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8: match counter width.
REQ-005 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port seq_in, input, 1 bit: serial data bit.
REQ-008 SHALL have port seq_valid, input, 1 bit: seq_in is sampled only on edges where seq_valid=1.
REQ-009 SHALL have port pat_load, input, 1 bit: loads pat_in as the new pattern.
REQ-010 SHALL have port pat_in, input, PAT_W bits: runtime pattern, MSB first-received.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-012 SHALL have port detect_out, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have port match_cnt, output, CNT_W bits: saturating match count; exists only when SEQ_DET_CNT_EN is defined.

Function
REQ-014 SHALL keep a PAT_W-bit history register; each valid bit shifts in at the LSB.
REQ-015 SHALL keep a fill counter 0..PAT_W; it increments on each valid bit and saturates at PAT_W.
REQ-016 SHALL declare a match on an edge with seq_valid=1 when (fill>=PAT_W-1 before the edge) and {history[PAT_W-2:0],seq_in}==pattern.
REQ-017 SHALL drive detect_out=1 for exactly one cycle after the matching edge (latency 1); it is 0 otherwise, including on cycles with seq_valid=0.
REQ-018 With OVERLAP=1, SHALL retain history and fill after a match, so "10101" with pattern 101 gives two pulses.
REQ-019 With OVERLAP=0, SHALL force fill to 0 after a match, so the next match needs PAT_W fresh bits.
REQ-020 With seq_valid=0, SHALL hold history and fill unchanged.
REQ-021 On pat_load=1, SHALL load pat_in on that edge, clear fill and history, and force detect_out=0 next cycle.
REQ-022 When pat_load and seq_valid are both 1, pat_load SHALL win and the seq_in bit SHALL be discarded.
REQ-023 SHALL increment match_cnt by 1 per match, saturating at 2^CNT_W-1.
REQ-024 When cnt_clr and a match occur on the same edge, cnt_clr SHALL win and match_cnt SHALL become 0; detect_out still pulses.

Reset
REQ-025 While reset_in=1, SHALL asynchronously set pattern=RST_PAT, history=0, fill=0, detect_out=0, match_cnt=0.
REQ-026 Assertion of reset_in mid-sequence SHALL discard any partial match; detection restarts from fill=0 after release.

Configuration
REQ-027 When SEQ_DET_CNT_EN is defined, SHALL include the match_cnt port, the counter and cnt_clr behaviour.
REQ-028 When SEQ_DET_CNT_EN is undefined, SHALL omit the match_cnt port and the counter, ignore cnt_clr, and leave detect behaviour unchanged.

Structure
REQ-029 SHALL place fill-counter width localparam derivation (clog2(PAT_W+1)) and a mode constant enum {MODE_OVL, MODE_NOVL} in package seq_det_pkg.
REQ-030 SHALL implement history plus fill counter in sub-module seq_det_hist; compare, detect register and counter stay in seq_det_param.

Verification
REQ-031 Defaults, reset release, seq_in 1,0,1,0,1 with seq_valid=1 -> detect_out pulses in the cycles after bits 3 and 5; match_cnt=2.
REQ-032 OVERLAP=0, same stream -> one pulse after bit 3 only; match_cnt=1.
REQ-033 PAT_W=4, pat_load with pat_in=4'b1101, then bits 1,1,0,1 -> pulse after bit 4; a pulse does not occur for 1,0,1.
REQ-034 Bits 1,0 then seq_valid=0 for 5 cycles then bit 1 -> single pulse after the final bit; no pulse during the gap.
REQ-035 Bits 1,0, reset_in=1 asynchronously mid-cycle, release, bit 1 -> no pulse; detect_out=0 immediately on reset.
REQ-036 CNT_W=2, 5 matches -> match_cnt=3; cnt_clr coincident with the 6th match -> match_cnt=0 while detect_out pulses.
